// File: rtl/computer_pkg.sv
// Shared definitions for the computer's fetch path: default widths and the
// fetch sequencer state encoding.
package computer_pkg;

    // Default instruction word and address widths.
    localparam int unsigned WORD_W_DEF = 31;
    localparam int unsigned ADDR_W_DEF = 12;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: takes the start-register address on request,
// reads one word from memory and offers it to the decoder. Aborted reads are
// drained so a stale response can never reach the decoder.
module fetch_seq
    import computer_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] reg_start_value,
    output logic              do_reg_start_inc,
    output logic              mem_rd_req,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_word,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              busy
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic              inc_q, inc_d;

    // State and datapath registers; reset clears everything, dropping any
    // outstanding response and any pending increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            iaddr_q <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            iaddr_q <= iaddr_d;
            inc_q   <= inc_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        word_d      = word_q;
        iaddr_d     = iaddr_q;
        inc_d       = 1'b0;
        mem_rd_req  = 1'b0;
        instr_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_start && !abort) begin
                    addr_d  = reg_start_value;
                    state_d = StReq;
                end
            end
            StReq: begin
                mem_rd_req = 1'b1;
                if (abort) begin
                    // A read accepted this cycle will still respond; drain it.
                    state_d = mem_rd_ready ? StDrain : StIdle;
                end else if (mem_rd_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = mem_rd_valid ? StIdle : StDrain;
                end else if (mem_rd_valid) begin
                    word_d  = mem_rd_data;
                    iaddr_d = addr_q;
                    inc_d   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                instr_valid = 1'b1;
                if (abort || instr_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // Abort is ignored here: the response must be consumed.
                if (mem_rd_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_rd_addr      = addr_q;
    assign instr_word       = word_q;
    assign instr_addr       = iaddr_q;
    assign do_reg_start_inc = inc_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic        abort;
    logic [11:0] reg_start_value;
    logic        do_reg_start_inc;
    logic        mem_rd_req;
    logic        mem_rd_ready;
    logic [11:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [30:0] mem_rd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [30:0] instr_word;
    logic [11:0] instr_addr;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int inc_cnt = 0;
    int acc_cnt = 0;
    int inc_base;
    int acc_base;

    fetch_seq #(
        .WORD_W(31),
        .ADDR_W(12)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_start      (fetch_start),
        .abort            (abort),
        .reg_start_value  (reg_start_value),
        .do_reg_start_inc (do_reg_start_inc),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_ready     (mem_rd_ready),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_word       (instr_word),
        .instr_addr       (instr_addr),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: a request waiting for memory, a read owed by
    // memory (and whether it is still wanted), and a word on offer.
    typedef struct packed {
        logic        pend;
        logic        owed;
        logic        deliver;
        logic        present;
        logic        inc;
        logic [11:0] addr;
        logic [30:0] word;
        logic [11:0] iaddr;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic fs, logic ab, logic [11:0] rsv,
                                          logic rdy, logic vld, logic [30:0] d, logic ird);
        model_t n;
        n     = c;
        n.inc = 1'b0;
        if (!c.pend && !c.owed && !c.present) begin
            if (fs && !ab) begin
                n.addr = rsv;
                n.pend = 1'b1;
            end
        end else if (c.pend) begin
            if (rdy) begin
                n.pend    = 1'b0;
                n.owed    = 1'b1;
                n.deliver = !ab;
            end else if (ab) begin
                n.pend = 1'b0;
            end
        end else if (c.owed) begin
            if (vld) begin
                n.owed = 1'b0;
                if (c.deliver && !ab) begin
                    n.present = 1'b1;
                    n.word    = d;
                    n.iaddr   = c.addr;
                    n.inc     = 1'b1;
                end
            end else if (ab) begin
                n.deliver = 1'b0;
            end
        end else begin
            if (ab || ird) n.present = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= model_next(m, fetch_start, abort, reg_start_value, mem_rd_ready,
                             mem_rd_valid, mem_rd_data, instr_ready);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus event counters.
    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m.pend | m.owed | m.present));
        chk("mem_rd_req", 64'(mem_rd_req), 64'(m.pend));
        chk("instr_valid", 64'(instr_valid), 64'(m.present));
        chk("do_reg_start_inc", 64'(do_reg_start_inc), 64'(m.inc));
        if (m.pend) chk("mem_rd_addr", 64'(mem_rd_addr), 64'(m.addr));
        if (m.present) begin
            chk("instr_word", 64'(instr_word), 64'(m.word));
            chk("instr_addr", 64'(instr_addr), 64'(m.iaddr));
        end
        if (do_reg_start_inc) inc_cnt++;
        if (mem_rd_req && mem_rd_ready) acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        fetch_start  = 1'b0;
        abort        = 1'b0;
        mem_rd_valid = 1'b0;
    endtask

    // Zero-wait fetch of one word, taken by the decoder at once.
    task automatic quick_fetch(input logic [11:0] a, input logic [30:0] d);
        reg_start_value = a;
        fetch_start     = 1'b1;
        step();
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        fetch_start     = 1'b0;
        abort           = 1'b0;
        reg_start_value = '0;
        mem_rd_ready    = 1'b0;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        instr_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst instr_word", 64'(instr_word), 64'd0);
        chk("rst mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        reset = 1'b0;

        // Basic fetch with memory latency and a stalled decoder.
        inc_base        = inc_cnt;
        reg_start_value = 12'o0100;
        fetch_start     = 1'b1;
        step();
        chk("t1 req", 64'(mem_rd_req), 64'd1);
        chk("t1 addr", 64'(mem_rd_addr), 64'o0100);
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        step();
        mem_rd_valid = 1'b1;
        mem_rd_data  = 31'h12345678;
        step();
        chk("t1 inc", 64'(do_reg_start_inc), 64'd1);
        chk("t1 word", 64'(instr_word), 64'h12345678);
        chk("t1 iaddr", 64'(instr_addr), 64'o0100);
        for (int i = 0; i < 5; i++) begin
            fetch_start = 1'b1;
            step();
            chk("t1 hold valid", 64'(instr_valid), 64'd1);
            chk("t1 hold word", 64'(instr_word), 64'h12345678);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        chk("t1 no queued start", 64'(busy), 64'd0);
        chk("t1 inc count", 64'(inc_cnt - inc_base), 64'd1);

        // Minimum latency: instr_valid three edges after fetch_start.
        mem_rd_ready    = 1'b1;
        reg_start_value = 12'o0004;
        fetch_start     = 1'b1;
        step();
        step();
        mem_rd_ready = 1'b0;
        chk("lat edge2", 64'(instr_valid), 64'd0);
        mem_rd_valid = 1'b1;
        mem_rd_data  = 31'h0000_00aa;
        step();
        chk("lat edge3", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Abort in WAIT, response three cycles later is drained.
        inc_base        = inc_cnt;
        reg_start_value = 12'o0010;
        fetch_start     = 1'b1;
        step();
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        abort        = 1'b1;
        step();
        step();
        step();
        chk("drain busy", 64'(busy), 64'd1);
        mem_rd_valid = 1'b1;
        abort        = 1'b1;
        mem_rd_data  = 31'h7fff_ffff;
        step();
        chk("drain done", 64'(busy), 64'd0);
        chk("drain no inc", 64'(inc_cnt - inc_base), 64'd0);

        // Abort in REQ without and with a same-cycle ready.
        fetch_start = 1'b1;
        step();
        abort = 1'b1;
        step();
        chk("req abort idle", 64'(busy), 64'd0);
        fetch_start = 1'b1;
        step();
        abort        = 1'b1;
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        chk("req abort drain", 64'(busy), 64'd1);
        mem_rd_valid = 1'b1;
        step();

        // Abort in WAIT with a same-cycle valid; start+abort in IDLE.
        inc_base    = inc_cnt;
        fetch_start = 1'b1;
        step();
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        abort        = 1'b1;
        mem_rd_valid = 1'b1;
        step();
        chk("wait abort valid", 64'(busy), 64'd0);
        fetch_start = 1'b1;
        abort       = 1'b1;
        step();
        chk("idle start+abort", 64'(busy), 64'd0);
        chk("aborts no inc", 64'(inc_cnt - inc_base), 64'd0);

        // Abort in HOLD drops the offered word.
        reg_start_value = 12'o0020;
        fetch_start     = 1'b1;
        step();
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 31'h0000_0555;
        step();
        step();
        abort = 1'b1;
        step();
        chk("hold abort", 64'(instr_valid), 64'd0);

        // Top address, then address zero.
        inc_base = inc_cnt;
        reg_start_value = 12'o7777;
        fetch_start     = 1'b1;
        step();
        chk("top addr", 64'(mem_rd_addr), 64'o7777);
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 31'h0000_1234;
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("top inc count", 64'(inc_cnt - inc_base), 64'd1);
        reg_start_value = 12'o0000;
        fetch_start     = 1'b1;
        step();
        chk("zero addr", 64'(mem_rd_addr), 64'd0);
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1;
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Asynchronous reset in WAIT; late valid ignored; new fetch works.
        inc_base        = inc_cnt;
        reg_start_value = 12'o0055;
        fetch_start     = 1'b1;
        step();
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst req", 64'(mem_rd_req), 64'd0);
        chk("arst addr", 64'(mem_rd_addr), 64'd0);
        chk("arst iaddr", 64'(instr_addr), 64'd0);
        step();
        step();
        reset           = 1'b0;
        mem_rd_valid    = 1'b1;
        fetch_start     = 1'b1;
        reg_start_value = 12'o0200;
        step();
        chk("post rst accept", 64'(busy), 64'd1);
        chk("post rst addr", 64'(mem_rd_addr), 64'o0200);
        chk("post rst no inc", 64'(inc_cnt - inc_base), 64'd0);
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 31'h0abc_def0;
        step();
        chk("post rst word", 64'(instr_word), 64'h0abc_def0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Memory not ready for ten cycles.
        reg_start_value = 12'o0321;
        fetch_start     = 1'b1;
        step();
        reg_start_value = 12'o0000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall req", 64'(mem_rd_req), 64'd1);
            chk("stall addr", 64'(mem_rd_addr), 64'o0321);
        end
        acc_base     = acc_cnt;
        mem_rd_ready = 1'b1;
        step();
        step();
        mem_rd_ready = 1'b0;
        chk("one accept", 64'(acc_cnt - acc_base), 64'd1);
        mem_rd_valid = 1'b1;
        step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();

        quick_fetch(12'o1234, 31'h1357_2468);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter WORD_W, default 31, SHALL set the instruction word width in bits.
REQ-002 Parameter ADDR_W, default 12, SHALL set the address width and SHALL match the start-register width.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 fetch_start  in  1  SHALL be a one-cycle request from control to fetch the next instruction.
REQ-006 abort  in  1  SHALL be a synchronous cancel of the current fetch.
REQ-007 reg_start_value  in  ADDR_W  SHALL carry the current start-register contents.
REQ-008 do_reg_start_inc  out  1  SHALL be a one-cycle increment strobe to the start register.
REQ-009 mem_rd_req / mem_rd_ready  out/in  1/1  SHALL form the read-request handshake.
REQ-010 mem_rd_addr  out  ADDR_W  SHALL carry the read address.
REQ-011 mem_rd_valid / mem_rd_data  in/in  1/WORD_W  SHALL carry the read response.
REQ-012 instr_valid / instr_ready  out/in  1/1  SHALL form the handshake to the decoder.
REQ-013 instr_word  out  WORD_W  SHALL carry the fetched word.
REQ-014 instr_addr  out  ADDR_W  SHALL carry the address the word was fetched from.
REQ-015 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, REQ, WAIT, HOLD, DRAIN.
REQ-017 IDLE: on fetch_start with abort low, latch reg_start_value into the address register and go to REQ; otherwise stay.
REQ-018 REQ: assert mem_rd_req with mem_rd_addr held stable; when mem_rd_ready=1, go to WAIT the next cycle.
REQ-019 WAIT: on mem_rd_valid=1, capture mem_rd_data into instr_word, pulse do_reg_start_inc for exactly the following cycle, and go to HOLD.
REQ-020 HOLD: assert instr_valid with instr_word and instr_addr stable; when instr_ready=1, go to IDLE.
REQ-021 mem_rd_valid SHALL be sampled only in WAIT and DRAIN; the memory SHALL return data at least one cycle after mem_rd_ready.
REQ-022 fetch_start outside IDLE SHALL be ignored and not queued.
REQ-023 abort in REQ or HOLD SHALL go to IDLE with no increment; when REQ and mem_rd_ready are both high in the same cycle, abort SHALL go to DRAIN.
REQ-024 abort in WAIT SHALL go to DRAIN, or to IDLE when mem_rd_valid is high in the same cycle; no word SHALL be captured and no increment SHALL be issued.
REQ-025 DRAIN: on mem_rd_valid, discard the data and go to IDLE; abort in DRAIN SHALL be ignored.
REQ-026 do_reg_start_inc SHALL pulse exactly once per fetch delivered to HOLD and never otherwise; address wrap from 7777 octal to 0000 SHALL be left to the start register.
REQ-027 fetch_start and abort in the same IDLE cycle SHALL leave the block in IDLE.
REQ-028 Minimum latency from fetch_start to instr_valid SHALL be 3 cycles (zero-wait memory responding the cycle after ready).

Reset
REQ-029 While reset is high: state=IDLE; mem_rd_req, do_reg_start_inc, instr_valid and busy=0; the address register, instr_word and instr_addr=0.
REQ-030 Reset mid-fetch SHALL drop any outstanding response with no increment; after reset release the block SHALL accept fetch_start on the first clk edge.

Structure
REQ-031 The state encoding and ADDR_W/WORD_W defaults SHALL live in the shared computer_pkg package.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 reg_start_value=0o0100, fetch_start, ready immediate, valid after 2 cycles with data 0x12345678 -> mem_rd_addr=0o0100, one inc pulse, instr_word=0x12345678, instr_addr=0o0100.
REQ-034 instr_ready held low 5 cycles in HOLD -> instr_valid and instr_word stable for all 5 cycles; fetch_start pulses during HOLD are ignored.
REQ-035 abort in WAIT, then valid 3 cycles later -> DRAIN consumes the response, no inc, no instr_valid, busy drops after the valid.
REQ-036 reg_start_value=0o7777 -> mem_rd_addr=0o7777, single inc pulse; the next fetch with value 0o0000 -> address 0.
REQ-037 reset asserted asynchronously in WAIT -> outputs zero immediately; a late valid is ignored; a new fetch proceeds normally.
REQ-038 mem_rd_ready held low 10 cycles -> mem_rd_req and mem_rd_addr stable throughout; exactly one request is accepted.
